// File: rtl/fpa_arbiter_if.sv
// Bundle between the requesting datapath blocks, the arbiter and the shared FPA.
// The arbiter takes the slave view; requesters plus the FPA side take the master view.
interface fpa_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   ack;
  logic [W-1:0]   sum_out;
  logic           err;
  logic           busy;
  logic           fpa_clr;
  logic           fpa_go;
  logic [W-1:0]   fpa_a;
  logic [W-1:0]   fpa_b;
  logic           fpa_done;
  logic [W-1:0]   fpa_sum;

  modport slave (
    input  req, a_in, b_in, fpa_done, fpa_sum,
    output ack, sum_out, err, busy, fpa_clr, fpa_go, fpa_a, fpa_b
  );

  modport master (
    output req, a_in, b_in, fpa_done, fpa_sum,
    input  ack, sum_out, err, busy, fpa_clr, fpa_go, fpa_a, fpa_b
  );
endinterface

// File: rtl/fpa_arbiter.sv
// Round-robin arbiter/sequencer sharing one FPA among N requesters,
// with a WAIT timeout that returns err=1 and a zero sum.
module fpa_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         clr,
  fpa_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state_reg;
  logic [IW-1:0]  ptr_reg;
  logic [IW-1:0]  grant_reg;
  logic [CW-1:0]  cnt_reg;
  logic [N-1:0]   ack_reg;
  logic [W-1:0]   sum_reg;
  logic           err_reg;
  logic           busy_reg;
  logic           fpa_clr_reg;
  logic           fpa_go_reg;
  logic [W-1:0]   fpa_a_reg;
  logic [W-1:0]   fpa_b_reg;

  logic [W-1:0]   a_word [N];
  logic [W-1:0]   b_word [N];
  logic [IW-1:0]  cand_idx [N];
  logic [N-1:0]   cand_req;
  logic [N-1:0]   grant_oh;
  logic [IW-1:0]  pick_next;
  logic           any_req;
  logic [IW-1:0]  ptr_next;

  // cand_idx[gi] is the requester examined at search offset gi from ptr
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] raw;
    assign a_word[gi]   = bus.a_in[gi*W +: W];
    assign b_word[gi]   = bus.b_in[gi*W +: W];
    assign raw          = {1'b0, ptr_reg} + (IW+1)'(gi);
    assign cand_idx[gi] = (raw >= (IW+1)'(N)) ? IW'(raw - (IW+1)'(N)) : raw[IW-1:0];
    assign cand_req[gi] = bus.req[cand_idx[gi]];
    assign grant_oh[gi] = (grant_reg == IW'(gi));
  end

  assign any_req = |bus.req;

  // Scan from the far end so the smallest offset from ptr wins
  always_comb begin
    pick_next = ptr_reg;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        pick_next = cand_idx[k];
      end
    end
  end

  assign ptr_next = (grant_reg == IW'(N - 1)) ? '0 : grant_reg + IW'(1);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg   <= S_IDLE;
      ptr_reg     <= '0;
      grant_reg   <= '0;
      cnt_reg     <= '0;
      ack_reg     <= '0;
      sum_reg     <= '0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      fpa_clr_reg <= 1'b1;
      fpa_go_reg  <= 1'b0;
      fpa_a_reg   <= '0;
      fpa_b_reg   <= '0;
    end else begin
      ack_reg     <= '0;
      fpa_clr_reg <= 1'b0;
      fpa_go_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (any_req) begin
            grant_reg   <= pick_next;
            fpa_a_reg   <= a_word[pick_next];
            fpa_b_reg   <= b_word[pick_next];
            fpa_clr_reg <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          fpa_go_reg <= 1'b1;
          state_reg  <= S_LAUNCH;
        end
        S_LAUNCH: begin
          cnt_reg   <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          // done has priority over a timeout landing in the same cycle
          if (bus.fpa_done) begin
            sum_reg   <= bus.fpa_sum;
            err_reg   <= 1'b0;
            ack_reg   <= grant_oh;
            state_reg <= S_RESP;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            sum_reg   <= '0;
            err_reg   <= 1'b1;
            ack_reg   <= grant_oh;
            state_reg <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_RESP: begin
          ptr_reg   <= ptr_next;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack     = ack_reg;
  assign bus.sum_out = sum_reg;
  assign bus.err     = err_reg;
  assign bus.busy    = busy_reg;
  assign bus.fpa_clr = fpa_clr_reg;
  assign bus.fpa_go  = fpa_go_reg;
  assign bus.fpa_a   = fpa_a_reg;
  assign bus.fpa_b   = fpa_b_reg;
endmodule
